// File: rtl/newtag_arbiter_if.sv
// Request/response bundle for newtag_arbiter.
// The master side owns the requester and response-consumer signals,
// the slave side is the arbiter itself.
interface newtag_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic              rsp_tag;
  logic [CNTW-1:0]   hit_cnt;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, hit_cnt
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_tag, hit_cnt
  );
endinterface

// File: rtl/newtag_arbiter.sv
// newtag_arbiter: grants one of NREQ requesters, evaluates a tag function on
// the captured 8-bit vector and returns the result on a valid/ready response
// channel, counting (saturating) responses whose tag bit is 1.
// Optional feature: define NEWTAG_ROUND_ROBIN_EN for round-robin granting;
// otherwise the lowest-index valid requester wins.
module newtag_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input logic             clk,
  input logic             rst_n,
  newtag_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            grant_any;
  logic [2:0]      grant_idx;
  logic            accept;
  logic            deliver;
  logic [7:0]      sel_data;
  logic [7:0]      cap_data;
  logic            rsp_valid_q;
  logic            rsp_tag_q;
  logic [2:0]      rsp_id_q;
  logic [CNTW-1:0] hit_q;
  logic            n15;
  logic            n17;

`ifdef NEWTAG_ROUND_ROBIN_EN
  logic [2:0] rr_ptr;

  // Round-robin pick: scan starting one past the last granted index
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 3'd0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_any && bus.req_valid[j] &&
            (j == ((int'(rr_ptr) + k) % NREQ))) begin
          grant_any = 1'b1;
          grant_idx = 3'(j);
        end
      end
    end
  end

  // Remember the most recent grant so the next search starts after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 3'(NREQ - 1);
    end else if (accept) begin
      rr_ptr <= grant_idx;
    end
  end
`else
  // Fixed priority pick: lowest-index valid requester wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 3'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_any && bus.req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = 3'(j);
      end
    end
  end
`endif

  // Select the tag vector of the granted requester
  always_comb begin
    sel_data = 8'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx == 3'(j)) begin
        sel_data = bus.req_data[8*j +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus accept/deliver strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          accept     = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-hot acceptance strobe, forced low while reset is held
  always_comb begin
    bus.req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      bus.req_ready[j] = accept && rst_n && (grant_idx == 3'(j));
    end
  end

  // Capture the granted vector and index at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data <= 8'd0;
      rsp_id_q <= 3'd0;
    end else if (accept) begin
      cap_data <= sel_data;
      rsp_id_q <= grant_idx;
    end
  end

  assign n15 = cap_data[3] & ~(cap_data[4] & cap_data[5]) &
               ~((cap_data[4] | cap_data[5]) & cap_data[6] & cap_data[7]);
  assign n17 = ~cap_data[0] & cap_data[1] & ~cap_data[2];

  // Register the tag result in EVAL and hold rsp_valid until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_tag_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else if (state == EVAL) begin
      rsp_tag_q   <= n15 | ~n17;
      rsp_valid_q <= 1'b1;
    end else if (deliver) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Count delivered hits, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if (deliver && rsp_tag_q && (hit_q != {CNTW{1'b1}})) begin
      hit_q <= hit_q + CNTW'(1);
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.hit_cnt   = hit_q;

endmodule

// File: doc/newtag_arbiter.md
NEWTAG_ARBITER -- requirements
Module: newtag_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter CNTW, default 16, width of the hit counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  request valid, one bit per requester.
REQ-006 SHALL have port req_data  input  8*NREQ  8-bit tag vector per requester; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  NREQ  one-hot acceptance strobe, combinational.
REQ-008 SHALL have port rsp_valid  output  1  response valid.
REQ-009 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-010 SHALL have port rsp_id  output  3  index of the requester served.
REQ-011 SHALL have port rsp_tag  output  1  evaluated tag bit.
REQ-012 SHALL have port hit_cnt  output  CNTW  count of responses delivered with rsp_tag=1.

Function
REQ-013 SHALL run a three-state FSM: IDLE, EVAL, RESP.
REQ-014 In IDLE with any req_valid high, SHALL raise req_ready for exactly one granted index g.
- Same cycle: capture req_data[g] and g.
- Next state: EVAL.
REQ-015 In IDLE with no req_valid, SHALL hold all req_ready low and stay in IDLE.
REQ-016 req_ready SHALL be low in EVAL and RESP.
REQ-017 Transfer on a channel SHALL occur only when req_valid and req_ready are both high.
REQ-018 In EVAL, SHALL register rsp_tag = n15 | ~n17, where p[k] is captured bit k and:
- n15 = p3 & ~(p4&p5) & ~((p4|p5)&p6&p7)
- n17 = ~p0 & p1 & ~p2
- EVAL always proceeds to RESP.
REQ-019 In RESP, SHALL hold rsp_valid=1 with rsp_id and rsp_tag stable until rsp_ready=1.
- On that cycle: return to IDLE.
- If rsp_tag=1: hit_cnt increments by one.
REQ-020 rsp_valid SHALL be 0 in IDLE and EVAL.
REQ-021 Minimum request-to-rsp_valid latency SHALL be 2 cycles; maximum throughput is one request per 3 cycles.
REQ-022 hit_cnt SHALL saturate at all-ones and never wrap.
REQ-023 Requests arriving while not in IDLE SHALL wait; requesters hold req_valid and req_data until accepted.
REQ-024 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-025 When rst_n is low, SHALL asynchronously force the following, regardless of the operation in progress; any captured request is discarded:
- state = IDLE
- rsp_valid = 0, rsp_id = 0, rsp_tag = 0
- hit_cnt = 0
- round-robin pointer = NREQ-1
REQ-026 req_ready SHALL be all-zero while rst_n is low.
REQ-027 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-028 With macro NEWTAG_ROUND_ROBIN_EN defined, the grant SHALL follow round-robin order:
- Search starts at (last granted index + 1) mod NREQ.
- The pointer updates to g on each grant.
REQ-029 Without NEWTAG_ROUND_ROBIN_EN, the grant SHALL go to the lowest-index valid requester, and no pointer register is implemented.

Verification
REQ-030 Single request: requester 0 sends 0x02; then rsp_ready=1 -> req_ready[0] pulses 1 cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_tag=0, hit_cnt stays 0.
REQ-031 Tag-function vectors, each sent singly -> required rsp_tag:
- 0x00 -> 1
- 0x0A -> 1
- 0xCA -> 1
- 0xDA -> 0
- 0x3A -> 0
- After these five, hit_cnt=3.
REQ-032 All four requesters hold valid continuously with rsp_ready=1:
- With NEWTAG_ROUND_ROBIN_EN: rsp_id sequence 0,1,2,3,0.
- Without it: rsp_id sequence 0,0,0,0.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_tag held stable, no req_ready asserted, then one transfer when rsp_ready rises.
REQ-034 Reset in EVAL and reset in RESP:
- rst_n low -> rsp_valid=0 immediately and hit_cnt=0.
- After release, first grant goes to requester 0.
REQ-035 Saturation: preload via 2^CNTW-1 hits (CNTW=4 build: 15 hits), then one more hit -> hit_cnt stays 0xF.
